// File: rtl/noc_local_tx_if.sv
// rtl/noc_local_tx_if.sv - request, payload, flit and credit signals between a core and the local NoC transmitter
interface noc_local_tx_if #(
  parameter int FLIT_W  = 16,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_dst_x;
  logic [COORD_W-1:0] req_dst_y;
  logic [LEN_W-1:0]   req_len;
  logic               pay_valid;
  logic               pay_ready;
  logic [FLIT_W-1:0]  pay_data;
  logic               flit_valid;
  logic [1:0]         flit_type;
  logic [FLIT_W-1:0]  flit_data;
  logic               credit_in;

  modport master (
    input  req_valid, req_dst_x, req_dst_y, req_len, pay_valid, pay_data, credit_in,
    output req_ready, pay_ready, flit_valid, flit_type, flit_data
  );

  modport slave (
    output req_valid, req_dst_x, req_dst_y, req_len, pay_valid, pay_data, credit_in,
    input  req_ready, pay_ready, flit_valid, flit_type, flit_data
  );
endinterface

// File: rtl/noc_local_tx.sv
// rtl/noc_local_tx.sv - packetizes core requests into HEAD/BODY/TAIL flits under router credit flow control
module noc_local_tx #(
  parameter int FLIT_W  = 16,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 4,
  parameter int CREDITS = 4,
  parameter int XCOORD  = 2,
  parameter int YCOORD  = 2,
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  noc_local_tx_if.master bus,
  output logic [CW-1:0] credits,
  output logic          busy,
  output logic          err_credit,
  output logic          err_len
);
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] dst_x_q, dst_y_q;
  logic [LEN_W-1:0]   len_q, remaining_q;
  logic               has_credit;
  logic               head_launch, body_launch, launch, last_flit;
  logic [FLIT_W-1:0]  head_word;

  assign has_credit = (credits != '0);
  assign launch     = head_launch | body_launch;
  assign last_flit  = (remaining_q == LEN_W'(1));
  assign busy       = (state_q != IDLE);

  always_comb begin
    head_word = '0;
    head_word[FLIT_W-1 -: COORD_W]         = dst_x_q;
    head_word[FLIT_W-1-COORD_W -: COORD_W] = dst_y_q;
    head_word[2*COORD_W-1 -: COORD_W]      = COORD_W'(XCOORD);
    head_word[COORD_W-1:0]                 = COORD_W'(YCOORD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.pay_ready = 1'b0;
    head_launch   = 1'b0;
    body_launch   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && bus.req_len != '0) state_d = HEAD;
      end
      HEAD: begin
        if (has_credit) begin
          head_launch = 1'b1;
          state_d     = BODY;
        end
      end
      BODY: begin
        // Ready depends only on credits so the core never sees a combinational loop through pay_valid.
        bus.pay_ready = has_credit;
        if (bus.pay_valid && has_credit) begin
          body_launch = 1'b1;
          if (last_flit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_x_q        <= '0;
      dst_y_q        <= '0;
      len_q          <= '0;
      remaining_q    <= '0;
      bus.flit_valid <= 1'b0;
      bus.flit_type  <= 2'b00;
      bus.flit_data  <= '0;
      credits        <= CRED_MAX;
      err_credit     <= 1'b0;
      err_len        <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        dst_x_q <= bus.req_dst_x;
        dst_y_q <= bus.req_dst_y;
        len_q   <= bus.req_len;
        if (bus.req_len == '0) err_len <= 1'b1;
      end

      if (head_launch)      remaining_q <= len_q;
      else if (body_launch) remaining_q <= remaining_q - LEN_W'(1);

      bus.flit_valid <= launch;
      if (head_launch) begin
        bus.flit_type <= 2'b01;
        bus.flit_data <= head_word;
      end else if (body_launch) begin
        bus.flit_type <= last_flit ? 2'b10 : 2'b00;
        bus.flit_data <= bus.pay_data;
      end

      // A returned credit with nothing outstanding means the router and this block disagree.
      if (launch && !bus.credit_in) begin
        credits <= credits - CW'(1);
      end else if (!launch && bus.credit_in) begin
        if (credits == CRED_MAX) err_credit <= 1'b1;
        else                     credits    <= credits + CW'(1);
      end
    end
  end
endmodule
